// File: rtl/mem_dump_reader_pkg.sv
// rtl/mem_dump_reader_pkg.sv - shared widths and FSM encoding for the memory dump reader
//
// Purpose: default memory geometry and the dump FSM state type, shared by
// the reader RTL and anything that needs to decode its state.
// Ports: none (package).

package mem_dump_reader_pkg;

  localparam int DATA_W_DEFAULT = 32;  // memory word width
  localparam int ADDR_W_DEFAULT = 11;  // 2048-word memory

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_CAPT  = 3'd2,
    ST_SEND  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/mem_dump_reader.sv
// rtl/mem_dump_reader.sv - walks an inclusive address range and streams each word out
//
// Purpose: while the CPU is halted, read program/data memory over its second
// (synchronous) port from start_adrs to end_adrs inclusive and present each
// word with its address on a valid/ready stream.
// Ports:
//   clk, resetn               clock, asynchronous active-low reset
//   cpu_en                    CPU run enable; rising while busy aborts the dump
//   start, start_adrs,
//   end_adrs                  start pulse and inclusive range, sampled together
//   mem_rd_en, mem_rd_adrs    read strobe/address to memory (only in ISSUE)
//   mem_rd_data               read data, valid the cycle after mem_rd_en
//   dout_valid, dout_ready,
//   dout_data, dout_adrs      output word stream
//   busy, done, err           status: dump in progress, completion pulse,
//                             rejected-start / abort pulse

module mem_dump_reader
  import mem_dump_reader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_en,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_adrs,
  input  logic [ADDR_W-1:0] end_adrs,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_adrs,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout_data,
  output logic [ADDR_W-1:0] dout_adrs,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] ADRS_ONE = 1;

  state_t            state;
  logic [ADDR_W-1:0] cur_adrs;
  logic [ADDR_W-1:0] last_adrs;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      cur_adrs    <= '0;
      last_adrs   <= '0;
      mem_rd_en   <= 1'b0;
      mem_rd_adrs <= '0;
      dout_valid  <= 1'b0;
      dout_data   <= '0;
      dout_adrs   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (busy && cpu_en) begin
        // CPU restarted under us: drop everything, including a pending word.
        state      <= ST_IDLE;
        mem_rd_en  <= 1'b0;
        dout_valid <= 1'b0;
        busy       <= 1'b0;
        err        <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              if (!cpu_en && (end_adrs >= start_adrs)) begin
                cur_adrs    <= start_adrs;
                last_adrs   <= end_adrs;
                busy        <= 1'b1;
                // Strobe is registered, so it is raised on entry to ISSUE.
                mem_rd_en   <= 1'b1;
                mem_rd_adrs <= start_adrs;
                state       <= ST_ISSUE;
              end else begin
                err <= 1'b1;
              end
            end
          end
          ST_ISSUE: begin
            mem_rd_en <= 1'b0;
            state     <= ST_CAPT;
          end
          ST_CAPT: begin
            dout_data  <= mem_rd_data;
            dout_adrs  <= cur_adrs;
            dout_valid <= 1'b1;
            state      <= ST_SEND;
          end
          ST_SEND: begin
            if (dout_ready) begin
              dout_valid <= 1'b0;
              // Compare before incrementing so a range ending at the top
              // address never wraps cur_adrs back to zero.
              if (cur_adrs == last_adrs) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= ST_DONE;
              end else begin
                cur_adrs    <= cur_adrs + ADRS_ONE;
                mem_rd_en   <= 1'b1;
                mem_rd_adrs <= cur_adrs + ADRS_ONE;
                state       <= ST_ISSUE;
              end
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_dump_reader.sv
// tb/tb_mem_dump_reader.sv - scoreboard bench for the memory dump reader

module tb_mem_dump_reader;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cpu_en = 1'b0;
  logic        start = 1'b0;
  logic [10:0] start_adrs = '0;
  logic [10:0] end_adrs = '0;
  logic        mem_rd_en;
  logic [10:0] mem_rd_adrs;
  logic [31:0] mem_rd_data = '0;
  logic        dout_valid;
  logic        dout_ready = 1'b1;
  logic [31:0] dout_data;
  logic [10:0] dout_adrs;
  logic        busy;
  logic        done;
  logic        err;

  mem_dump_reader #(.DATA_W(32), .ADDR_W(11)) dut (
    .clk(clk), .resetn(resetn), .cpu_en(cpu_en), .start(start),
    .start_adrs(start_adrs), .end_adrs(end_adrs),
    .mem_rd_en(mem_rd_en), .mem_rd_adrs(mem_rd_adrs), .mem_rd_data(mem_rd_data),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .dout_adrs(dout_adrs), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:2047];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_adrs];

  typedef struct packed { logic [10:0] adrs; logic [31:0] data; } beat_t;
  beat_t exp_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int hs_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every presented word against the scoreboard head and
  // retire it on handshake.
  always @(negedge clk) begin
    if (mem_rd_en) rd_cnt++;
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (dout_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got adrs %0d data %0h expected none", dout_adrs, dout_data);
      end else begin
        check("beat_adrs", 64'(dout_adrs), 64'(exp_q[0].adrs));
        check("beat_data", 64'(dout_data), 64'(exp_q[0].data));
        if (dout_ready) begin
          void'(exp_q.pop_front());
          hs_cnt++;
        end
      end
    end
  end

  task automatic push(input logic [10:0] a, input logic [31:0] d);
    beat_t b;
    b.adrs = a;
    b.data = d;
    exp_q.push_back(b);
  endtask

  task automatic do_start(input logic [10:0] s, input logic [10:0] e);
    start_adrs = s;
    end_adrs   = e;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic wait_done(input int base, input int limit, input string name);
    int i;
    for (i = 0; i < limit; i++) begin
      @(negedge clk); #1;
      if (done_cnt > base) break;
    end
    check(name, 64'(done_cnt - base), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_hs(input int target, input int limit, input string name);
    int i;
    for (i = 0; i < limit; i++) begin
      @(negedge clk); #1;
      if (hs_cnt >= target) break;
    end
    check(name, 64'(hs_cnt >= target), 64'd1);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({mem_rd_en, mem_rd_adrs, dout_valid, dout_data, dout_adrs, busy, done, err});
  endfunction

  initial begin
    int b_done, b_err, b_rd, b_hs;
    for (int a = 0; a < 2048; a++) mem[a] = 32'(a * 3);
    mem[7]    = 32'h12345678;
    mem[2047] = 32'hDEADBEEF;

    #2;
    check("reset_outputs", all_outs(), 64'd0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check("post_reset_idle", all_outs(), 64'd0);
    @(posedge clk); #1;

    // 1: single word, latency
    b_done = done_cnt;
    push(11'd7, 32'h12345678);
    do_start(11'd7, 11'd7);
    @(negedge clk);
    check("t1_rd_en", 64'(mem_rd_en), 64'd1);
    check("t1_rd_adrs", 64'(mem_rd_adrs), 64'd7);
    check("t1_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("t1_valid_early", 64'(dout_valid), 64'd0);
    @(negedge clk);
    check("t1_valid_lat3", 64'(dout_valid), 64'd1);
    wait_done(b_done, 20, "t1_done");
    check("t1_busy_after", 64'(busy), 64'd0);

    // 2: stall on the second word
    b_done = done_cnt;
    b_hs = hs_cnt;
    push(11'd4, 32'd12);
    push(11'd5, 32'd15);
    push(11'd6, 32'd18);
    do_start(11'd4, 11'd6);
    wait_hs(b_hs + 1, 20, "t2_first_hs");
    @(posedge clk); #1 dout_ready = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("t2_stalled_valid", 64'(dout_valid), 64'd1);
    check("t2_hs_during_stall", 64'(hs_cnt - b_hs), 64'd1);
    dout_ready = 1'b1;
    wait_done(b_done, 30, "t2_done");
    check("t2_handshakes", 64'(hs_cnt - b_hs), 64'd3);

    // 3: rejected starts
    b_err = err_cnt;
    b_rd = rd_cnt;
    cpu_en = 1'b1;
    do_start(11'd0, 11'd3);
    @(negedge clk);
    check("t3_err_cpu_en", 64'(err), 64'd1);
    check("t3_busy_cpu_en", 64'(busy), 64'd0);
    @(posedge clk); #1 cpu_en = 1'b0;
    do_start(11'd9, 11'd3);
    @(negedge clk);
    check("t3_err_range", 64'(err), 64'd1);
    check("t3_busy_range", 64'(busy), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    check("t3_no_access", 64'(rd_cnt - b_rd), 64'd0);
    check("t3_err_pulses", 64'(err_cnt - b_err), 64'd2);

    // 4: top of memory, no wrap
    b_done = done_cnt;
    b_hs = hs_cnt;
    for (int a = 2040; a < 2047; a++) push(11'(a), 32'(a * 3));
    push(11'd2047, 32'hDEADBEEF);
    do_start(11'd2040, 11'd2047);
    wait_done(b_done, 40, "t4_done");
    check("t4_handshakes", 64'(hs_cnt - b_hs), 64'd8);
    repeat (4) @(posedge clk);
    #1;
    check("t4_idle_no_wrap", 64'({busy, dout_valid, mem_rd_en}), 64'd0);

    // 5: abort after second handshake, then restart
    b_done = done_cnt;
    b_hs = hs_cnt;
    for (int a = 0; a < 16; a++) push(11'(a), 32'(a * 3));
    do_start(11'd0, 11'd15);
    wait_hs(b_hs + 2, 30, "t5_two_hs");
    @(posedge clk); #1 cpu_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t5_abort_err", 64'(err), 64'd1);
    check("t5_abort_outs", 64'({dout_valid, mem_rd_en, busy}), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    check("t5_no_done", 64'(done_cnt - b_done), 64'd0);
    check("t5_hs_count", 64'(hs_cnt - b_hs), 64'd2);
    exp_q.delete();
    cpu_en = 1'b0;
    @(posedge clk); #1;
    b_done = done_cnt;
    push(11'd3, 32'd9);
    do_start(11'd3, 11'd3);
    wait_done(b_done, 20, "t5_restart_done");

    // 6: async reset while a word is stalled, then start while busy
    dout_ready = 1'b0;
    push(11'd1, 32'd3);
    do_start(11'd1, 11'd15);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dout_valid) break;
    end
    check("t6_reached_send", 64'(dout_valid), 64'd1);
    #2 resetn = 1'b0;
    #1;
    check("t6_async_clear", all_outs(), 64'd0);
    exp_q.delete();
    @(posedge clk); #1 resetn = 1'b1;
    dout_ready = 1'b1;
    b_rd = rd_cnt;
    repeat (6) @(posedge clk);
    #1;
    check("t6_idle_after_reset", 64'({busy, dout_valid, rd_cnt - b_rd}), 64'd0);
    b_done = done_cnt;
    b_err = err_cnt;
    b_hs = hs_cnt;
    push(11'd10, 32'd30);
    push(11'd11, 32'd33);
    push(11'd12, 32'd36);
    do_start(11'd10, 11'd12);
    @(posedge clk); #1;
    do_start(11'd0, 11'd1);
    wait_done(b_done, 30, "t6_done");
    repeat (6) @(posedge clk);
    #1;
    check("t6_busy_start_no_err", 64'(err_cnt - b_err), 64'd0);
    check("t6_handshakes", 64'(hs_cnt - b_hs), 64'd3);
    check("t6_single_done", 64'(done_cnt - b_done), 64'd1);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
